button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 3, consecutive clk cycles a synchronized input must differ from its stable value before the stable value flips (legal range 1..15).
REQ-002 Port: clk  in  1  system clock (100 Hz meter clock).
REQ-003 Port: rst  in  1  reset, synchronous, active-high; clock clk.
REQ-004 Port: btn_raw  in  6  asynchronous raw buttons, index 0..5 = rst1, rst2, add1, add2, add3, add4.
REQ-005 Port: rst1_p, rst2_p, add1_p, add2_p, add3_p, add4_p  out  1 each  registered single-cycle command pulses to the parking meter.
REQ-006 Port: busy  out  1  registered; high while any press is pending issue.

Function
REQ-007 Each btn_raw bit SHALL pass through a 2-flop synchronizer (s1 then s2) before any other use.
REQ-008 Per button, the debounce counter SHALL increment each cycle s2 differs from the stable value and clear to 0 in any cycle s2 equals it.
REQ-009 When the counter would reach DEBOUNCE_CYCLES, stable SHALL toggle and the counter SHALL clear on that same edge.
REQ-010 A 0->1 stable toggle SHALL set that button's pending bit on the same edge; a 1->0 toggle SHALL set nothing.
REQ-011 Each cycle with any pending bit set, the arbiter SHALL grant exactly one, fixed priority rst1 > rst2 > add1 > add2 > add3 > add4, drive the matching pulse high for the next cycle only, and clear that pending bit.
REQ-012 At most one of the six pulse outputs SHALL be high in any cycle.
REQ-013 If a pending bit is granted and re-set by a new edge on the same edge, set SHALL win (the bit stays pending).
REQ-014 Uncontended latency: raw held high from before edge 0, pulse SHALL be high between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
REQ-015 A button held indefinitely SHALL produce exactly one pulse; a new pulse requires a debounced release and a fresh debounced press.
REQ-016 Input high for fewer than DEBOUNCE_CYCLES consecutive synchronized cycles SHALL produce no pulse.
REQ-017 Pending presses SHALL never be dropped; the maximum backlog is six, draining one per cycle.
REQ-018 busy SHALL be registered as the OR of pending bits after the current edge's set/clear.

Reset
REQ-019 On rst, all synchronizer flops, stable values, counters, pending bits, pulse outputs and busy SHALL go to 0 on that edge.
REQ-020 rst SHALL override all set/grant activity in the same cycle; pending presses at reset are discarded.
REQ-021 A button held through reset SHALL be treated as a new press after rst deasserts, following REQ-014 latency from the first post-reset edge.

Structure
REQ-022 Shared package parking_pkg SHALL hold button index constants (BTN_RST1..BTN_ADD4), NUM_BTN=6 and DEBOUNCE_CYCLES default.
REQ-023 Per-button synchronizer+debounce+edge detect SHALL be sub-module btn_debounce, instantiated six times; the arbiter and output registers live in the top.
REQ-024 Counter width SHALL be 4 bits.

Verification (DEBOUNCE_CYCLES=3)
REQ-025 Clean add1 press held 10 cycles from edge 0 -> add1_p high only edges 5-6; all other pulses 0.
REQ-026 add2 raw toggles 1,0,1,0,1,0 per cycle, then steady 1 -> exactly one add2_p, 5 cycles after steady level begins.
REQ-027 rst1, add2, add4 debounce-complete on the same edge -> rst1_p, add2_p, add4_p on three consecutive cycles; busy high for 3 cycles, then 0.
REQ-028 add3 held 200 cycles, released 10, pressed again -> exactly two add3_p pulses; 2-cycle glitch on add4 -> no add4_p.
REQ-029 add1 pressed, rst asserted one cycle at edge 3 while held -> no pulse before reset; one add1_p 5 cycles after first post-reset edge.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: button indices and debounce defaults shared by the parking meter blocks
package parking_pkg;
   localparam int NUM_BTN = 6;
   localparam int BTN_RST1 = 0;
   localparam int BTN_RST2 = 1;
   localparam int BTN_ADD1 = 2;
   localparam int BTN_ADD2 = 3;
   localparam int BTN_ADD3 = 4;
   localparam int BTN_ADD4 = 5;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 3;
   localparam int CNT_W = 4;
   typedef logic [NUM_BTN-1:0] btn_vec_t;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw buttons in, command pulses and busy out
interface button_conditioner_if;
   import parking_pkg::*;
   btn_vec_t btn_raw;
   logic     rst1_p;
   logic     rst2_p;
   logic     add1_p;
   logic     add2_p;
   logic     add3_p;
   logic     add4_p;
   logic     busy;
   modport master (output btn_raw, input rst1_p, rst2_p, add1_p, add2_p, add3_p, add4_p, busy);
   modport slave  (input btn_raw, output rst1_p, rst2_p, add1_p, add2_p, add3_p, add4_p, busy);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debounce counter and debounced rising-edge strobe
module btn_debounce
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic rise_o
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic             s1_q, s2_q, stable_q, stable_d, hit;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      hit      = (s2_q != stable_q) && (cnt_q == LAST);
      cnt_d    = (s2_q == stable_q || hit) ? '0 : cnt_q + 1'b1;
      stable_d = hit ? ~stable_q : stable_q;
      rise_o   = hit & ~stable_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces six meter buttons and issues one command pulse per press,
// fixed priority rst1 > rst2 > add1 > add2 > add3 > add4
module button_conditioner
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input logic                 clk,
   input logic                 rst,
   button_conditioner_if.slave bus
);
   btn_vec_t rise, grant, pending_q, pending_d, pulse_q;
   logic     busy_q;
   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .rst    (rst),
         .raw_i  (bus.btn_raw[b]),
         .rise_o (rise[b])
      );
   end
   // lowest set bit wins, so index 0 (rst1) has top priority; a new rise beats the clear
   always_comb begin
      grant     = pending_q & (~pending_q + 1'b1);
      pending_d = (pending_q & ~grant) | rise;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         pulse_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         pulse_q   <= grant;
         busy_q    <= |pending_d;
      end
   end
   assign bus.rst1_p = pulse_q[BTN_RST1];
   assign bus.rst2_p = pulse_q[BTN_RST2];
   assign bus.add1_p = pulse_q[BTN_ADD1];
   assign bus.add2_p = pulse_q[BTN_ADD2];
   assign bus.add3_p = pulse_q[BTN_ADD3];
   assign bus.add4_p = pulse_q[BTN_ADD4];
   assign bus.busy   = busy_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of latency, priority, glitch rejection and reset
module tb_button_conditioner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cnt[6] = '{default: 0};
   int   snap[6];
   int   multi = 0;
   logic [5:0] p;
   button_conditioner_if bus();
   button_conditioner #(.DEBOUNCE_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   assign p = {bus.add4_p, bus.add3_p, bus.add2_p, bus.add1_p, bus.rst2_p, bus.rst1_p};
   always @(negedge clk) begin
      for (int i = 0; i < 6; i++) if (p[i]) cnt[i]++;
      if ($countones(p) > 1) multi++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic mark();
      for (int i = 0; i < 6; i++) snap[i] = cnt[i];
   endtask
   initial begin
      bus.btn_raw = '0;
      tick(2);
      rst = 1'b0;
      chk("rst_pulses", {26'd0, p}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      tick(3);
      chk("idle_pulses", {26'd0, p}, 0);
      // clean add1 press, edge 0 is the next edge
      mark();
      bus.btn_raw = 6'b000100;
      tick(5);
      chk("add1_e4_pulses", {26'd0, p}, 0);
      chk("add1_e4_busy", {31'd0, bus.busy}, 1);
      tick(1);
      chk("add1_e5_pulses", {26'd0, p}, 6'b000100);
      chk("add1_e5_busy", {31'd0, bus.busy}, 0);
      tick(1);
      chk("add1_e6_pulses", {26'd0, p}, 0);
      tick(3);
      bus.btn_raw = '0;
      tick(8);
      chk("add1_count", cnt[2] - snap[2], 1);
      chk("add1_others", (cnt[0] - snap[0]) + (cnt[1] - snap[1]) + (cnt[3] - snap[3]) + (cnt[4] - snap[4]) + (cnt[5] - snap[5]), 0);
      // add2 bouncing then steady
      mark();
      for (int i = 0; i < 6; i++) begin
         bus.btn_raw[3] = (i % 2 == 0);
         tick(1);
      end
      bus.btn_raw[3] = 1'b1;
      tick(5);
      chk("add2_e4_pulses", {26'd0, p}, 0);
      chk("add2_bounce_count", cnt[3] - snap[3], 0);
      tick(1);
      chk("add2_e5_pulses", {26'd0, p}, 6'b001000);
      tick(10);
      bus.btn_raw = '0;
      tick(8);
      chk("add2_count", cnt[3] - snap[3], 1);
      // rst1, add2, add4 debounce together
      bus.btn_raw = 6'b101001;
      tick(5);
      chk("tri_e4_pulses", {26'd0, p}, 0);
      chk("tri_e4_busy", {31'd0, bus.busy}, 1);
      tick(1);
      chk("tri_e5_pulses", {26'd0, p}, 6'b000001);
      chk("tri_e5_busy", {31'd0, bus.busy}, 1);
      tick(1);
      chk("tri_e6_pulses", {26'd0, p}, 6'b001000);
      chk("tri_e6_busy", {31'd0, bus.busy}, 1);
      tick(1);
      chk("tri_e7_pulses", {26'd0, p}, 6'b100000);
      chk("tri_e7_busy", {31'd0, bus.busy}, 0);
      tick(1);
      chk("tri_e8_pulses", {26'd0, p}, 0);
      bus.btn_raw = '0;
      tick(8);
      // add3 long hold, release, repress; 2-cycle glitch on add4
      mark();
      for (int i = 0; i < 200; i++) begin
         bus.btn_raw[4] = 1'b1;
         bus.btn_raw[5] = (i < 2);
         tick(1);
      end
      bus.btn_raw[4] = 1'b0;
      tick(10);
      chk("add3_hold_count", cnt[4] - snap[4], 1);
      bus.btn_raw[4] = 1'b1;
      tick(20);
      bus.btn_raw = '0;
      tick(10);
      chk("add3_count", cnt[4] - snap[4], 2);
      chk("add4_glitch_count", cnt[5] - snap[5], 0);
      // reset while add1 held
      mark();
      bus.btn_raw = 6'b000100;
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rstheld_pulses", {26'd0, p}, 0);
      chk("rstheld_busy", {31'd0, bus.busy}, 0);
      tick(5);
      chk("rstheld_e4_pulses", {26'd0, p}, 0);
      chk("rstheld_e4_busy", {31'd0, bus.busy}, 1);
      tick(1);
      chk("rstheld_e5_pulses", {26'd0, p}, 6'b000100);
      tick(5);
      bus.btn_raw = '0;
      tick(8);
      chk("rstheld_count", cnt[2] - snap[2], 1);
      // full backlog of six drains one per cycle
      bus.btn_raw = 6'b111111;
      tick(5);
      chk("all_e4_pulses", {26'd0, p}, 0);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk($sformatf("all_grant%0d", i), {26'd0, p}, 32'd1 << i);
         chk($sformatf("all_busy%0d", i), {31'd0, bus.busy}, (i < 5) ? 1 : 0);
      end
      tick(1);
      chk("all_done_pulses", {26'd0, p}, 0);
      bus.btn_raw = '0;
      tick(8);
      chk("onehot_violations", multi, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
